wb_ctrl: RTL and testbench

Writeback-stage controller for the RV32I pipeline. It sits in front of the writeback mux and register file. It registers the writeback select, destination register and write enable for each retiring instruction. For loads and stores, it sequences the data-memory request/acknowledge handshake, stalls upstream stages while it waits, and aborts on flush or bus timeout.

---
 rtl/wb_pkg.sv | 33 +++
 rtl/wb_ctrl.sv | 169 ++++++++++++++++
 tb/tb_wb_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the writeback-stage controller.
//   wb_sel_e        : writeback mux select encodings
//   wb_state_e      : controller FSM states
//   RD_W            : register-file address width
//   wb_sel_legalize : maps reserved select encodings onto the ALU path
package wb_pkg;

    localparam int unsigned RD_W = 5;

    typedef enum logic [2:0] {
        WB_ALU    = 3'b000,
        WB_LOAD   = 3'b001,
        WB_IMM    = 3'b010,
        WB_IADDER = 3'b011,
        WB_PC4    = 3'b101
    } wb_sel_e;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } wb_state_e;

    // Reserved encodings (100, 110, 111) fall back to the ALU result.
    function automatic logic [2:0] wb_sel_legalize(input logic [2:0] sel);
        logic [2:0] legal;
        case (sel)
            3'b100, 3'b110, 3'b111: legal = WB_ALU;
            default:                legal = sel;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/wb_ctrl.sv
// wb_ctrl: writeback-stage controller for the RV32I pipeline.
// Registers writeback select / destination / write strobe for retiring
// instructions and sequences the data-memory handshake for loads and stores.
// Ports:
//   clk_in, rst_in            : clock, synchronous active-high reset
//   instr_valid_in            : retiring instruction presented
//   wb_mux_sel_in, rf_wr_en_in, rd_addr_in : decoded writeback controls
//   mem_load_in, mem_store_in : memory op type (mutually exclusive)
//   flush_in                  : kill presented / in-flight instruction
//   dmem_ack_in               : data memory completes the request
//   dmem_req_o, dmem_we_o     : data memory request and store flag
//   stall_o                   : combinational upstream hold
//   wb_mux_sel_reg_o, rf_wr_en_o, rd_addr_o : registered writeback controls
//   bus_err_o                 : one-cycle pulse on request timeout
module wb_ctrl
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            instr_valid_in,
    input  logic [2:0]      wb_mux_sel_in,
    input  logic            rf_wr_en_in,
    input  logic [RD_W-1:0] rd_addr_in,
    input  logic            mem_load_in,
    input  logic            mem_store_in,
    input  logic            flush_in,
    input  logic            dmem_ack_in,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic            stall_o,
    output logic [2:0]      wb_mux_sel_reg_o,
    output logic            rf_wr_en_o,
    output logic [RD_W-1:0] rd_addr_o,
    output logic            bus_err_o
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    wb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic            wr_q, wr_d;
    logic            err_q, err_d;
    logic [2:0]      sel_q, sel_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic [RD_W-1:0] rd_cap_q, rd_cap_d;

    logic is_mem;
    logic tmo_hit;

    assign is_mem  = mem_load_in | mem_store_in;
    assign tmo_hit = (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush beats ack, ack beats timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (instr_valid_in && !flush_in && is_mem) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (flush_in || dmem_ack_in || tmo_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values and combinational stall
    always_comb begin
        stall_o  = 1'b0;
        cnt_d    = cnt_q;
        req_d    = req_q;
        we_d     = we_q;
        wr_d     = 1'b0;
        err_d    = 1'b0;
        sel_d    = sel_q;
        rd_d     = rd_q;
        rd_cap_d = rd_cap_q;
        case (state_q)
            IDLE: begin
                req_d = 1'b0;
                we_d  = 1'b0;
                if (instr_valid_in && !flush_in) begin
                    if (is_mem) begin
                        stall_o  = 1'b1;
                        req_d    = 1'b1;
                        we_d     = mem_store_in;
                        rd_cap_d = rd_addr_in;
                        cnt_d    = '0;
                    end else begin
                        wr_d  = rf_wr_en_in && (rd_addr_in != '0);
                        rd_d  = rd_addr_in;
                        sel_d = wb_sel_legalize(wb_mux_sel_in);
                    end
                end
            end
            MEM_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (flush_in) begin
                    req_d = 1'b0;
                    we_d  = 1'b0;
                end else if (dmem_ack_in) begin
                    req_d = 1'b0;
                    we_d  = 1'b0;
                    // we_q doubles as the captured store flag
                    if (!we_q) begin
                        wr_d  = (rd_cap_q != '0);
                        rd_d  = rd_cap_q;
                        sel_d = WB_LOAD;
                    end
                end else if (tmo_hit) begin
                    req_d = 1'b0;
                    we_d  = 1'b0;
                    err_d = 1'b1;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            sel_q    <= WB_ALU;
            rd_q     <= '0;
            rd_cap_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            we_q     <= we_d;
            wr_q     <= wr_d;
            err_q    <= err_d;
            sel_q    <= sel_d;
            rd_q     <= rd_d;
            rd_cap_q <= rd_cap_d;
        end
    end

    assign dmem_req_o       = req_q;
    assign dmem_we_o        = we_q;
    assign rf_wr_en_o       = wr_q;
    assign bus_err_o        = err_q;
    assign wb_mux_sel_reg_o = sel_q;
    assign rd_addr_o        = rd_q;

endmodule

// File: tb/tb_wb_ctrl.sv
// tb_wb_ctrl: directed and randomized bench for wb_ctrl against a
// transaction-level model (busy flag, wait-cycle count, pending op).
module tb_wb_ctrl;
    import wb_pkg::*;

    localparam int unsigned TMO = 4;

    logic       clk = 1'b0;
    logic       rst, valid, wen, ld, st, flush, ack;
    logic [2:0] sel;
    logic [4:0] rd;
    logic       dmem_req, dmem_we, stall, rf_wr_en, bus_err;
    logic [2:0] sel_reg;
    logic [4:0] rd_reg;

    int checks = 0;
    int errors = 0;
    int stall_seen = 0;

    // Model state
    bit         m_busy = 0;
    int         m_wait = 0;
    bit         m_store = 0;
    logic [4:0] m_rd = '0;
    bit         e_req = 0, e_we = 0, e_wr = 0, e_err = 0, e_known = 0;
    logic [2:0] e_sel = '0;
    logic [4:0] e_rd = '0;

    always #5 clk = ~clk;

    wb_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .instr_valid_in   (valid),
        .wb_mux_sel_in    (sel),
        .rf_wr_en_in      (wen),
        .rd_addr_in       (rd),
        .mem_load_in      (ld),
        .mem_store_in     (st),
        .flush_in         (flush),
        .dmem_ack_in      (ack),
        .dmem_req_o       (dmem_req),
        .dmem_we_o        (dmem_we),
        .stall_o          (stall),
        .wb_mux_sel_reg_o (sel_reg),
        .rf_wr_en_o       (rf_wr_en),
        .rd_addr_o        (rd_reg),
        .bus_err_o        (bus_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check stall, advance model, check registered outputs.
    task automatic cyc(input logic i_rst, input logic i_valid, input logic [2:0] i_sel,
                       input logic i_wen, input logic [4:0] i_rd, input logic i_ld,
                       input logic i_st, input logic i_flush, input logic i_ack);
        bit exp_stall;
        rst = i_rst; valid = i_valid; sel = i_sel; wen = i_wen; rd = i_rd;
        ld = i_ld; st = i_st; flush = i_flush; ack = i_ack;
        #1;
        if (!m_busy) exp_stall = i_valid && !i_flush && (i_ld || i_st);
        else         exp_stall = !(i_flush || i_ack || (m_wait == int'(TMO) - 1));
        if (!i_rst) check_eq("stall", stall, exp_stall);
        if (stall) stall_seen++;

        e_wr  = 0;
        e_err = 0;
        if (i_rst) begin
            m_busy = 0; e_req = 0; e_we = 0; e_sel = '0; e_rd = '0; e_known = 1;
        end else if (!m_busy) begin
            e_req = 0; e_we = 0;
            if (i_valid && !i_flush) begin
                if (i_ld || i_st) begin
                    m_busy = 1; m_wait = 0; m_store = i_st; m_rd = i_rd;
                    e_req = 1; e_we = i_st; e_known = 0;
                end else begin
                    e_wr    = i_wen && (i_rd != 0);
                    e_rd    = i_rd;
                    e_sel   = (i_sel == 3'd4 || i_sel == 3'd6 || i_sel == 3'd7) ? 3'd0 : i_sel;
                    e_known = 1;
                end
            end else if (i_valid) begin
                e_known = 0;
            end
        end else begin
            if (i_flush) begin
                m_busy = 0; e_req = 0; e_we = 0; e_known = 0;
            end else if (i_ack) begin
                m_busy = 0; e_req = 0; e_we = 0;
                if (!m_store) begin
                    e_wr = (m_rd != 0); e_sel = 3'd1; e_rd = m_rd; e_known = 1;
                end else begin
                    e_known = 0;
                end
            end else if (m_wait == int'(TMO) - 1) begin
                m_busy = 0; e_req = 0; e_we = 0; e_err = 1; e_known = 0;
            end else begin
                m_wait++;
            end
        end

        @(posedge clk);
        #1;
        check_eq("dmem_req", dmem_req, e_req);
        check_eq("dmem_we", dmem_we, e_we);
        check_eq("rf_wr_en", rf_wr_en, e_wr);
        check_eq("bus_err", bus_err, e_err);
        if (e_known) begin
            check_eq("wb_sel", sel_reg, e_sel);
            check_eq("rd_addr", rd_reg, e_rd);
        end
    endtask

    task automatic idle(input logic i_ack);
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, i_ack);
    endtask

    task automatic alu(input logic [4:0] i_rd, input logic [2:0] i_sel, input logic i_wen);
        cyc(1'b0, 1'b1, i_sel, i_wen, i_rd, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic mem(input logic [4:0] i_rd, input logic i_store);
        cyc(1'b0, 1'b1, 3'd0, 1'b1, i_rd, !i_store, i_store, 1'b0, 1'b0);
    endtask

    initial begin
        logic r_valid, r_ld, r_st;
        logic [4:0] r_rd;
        int kind;

        cyc(1'b1, 1'b0, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("reset_rd", rd_reg, 32'd0);

        // ALU op to rd 5
        stall_seen = 0;
        alu(5'd5, 3'd0, 1'b1);
        check_eq("alu_rd5", rd_reg, 32'd5);
        idle(1'b0);
        check_eq("alu_nostall", stall_seen, 32'd0);

        // Load rd 7, ack 3 cycles after request rises
        stall_seen = 0;
        mem(5'd7, 1'b0);
        idle(1'b0); idle(1'b0); idle(1'b0);
        idle(1'b1);
        check_eq("ld_stall_len", stall_seen, 32'd4);
        check_eq("ld_sel", sel_reg, 32'd1);
        idle(1'b0);

        // Store, ack in first request cycle
        stall_seen = 0;
        mem(5'd9, 1'b1);
        idle(1'b1);
        check_eq("st_stall_len", stall_seen, 32'd1);
        idle(1'b0);

        // Load timeout, then ALU op
        mem(5'd3, 1'b0);
        repeat (TMO) idle(1'b0);
        alu(5'd12, 3'd2, 1'b1);

        // Load with flush and ack together, then ALU op to x0
        mem(5'd4, 1'b0);
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        alu(5'd0, 3'd0, 1'b1);

        // Ack on the timeout cycle wins
        mem(5'd11, 1'b0);
        repeat (TMO - 1) idle(1'b0);
        idle(1'b1);

        // Reserved selects collapse to ALU
        alu(5'd6, 3'd6, 1'b1);
        alu(5'd6, 3'd4, 1'b1);
        alu(5'd6, 3'd5, 1'b1);

        // Reset mid-transaction, later ack ignored; ack in IDLE ignored
        mem(5'd8, 1'b0);
        idle(1'b0);
        cyc(1'b1, 1'b0, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r_valid = ($urandom_range(0, 9) < 6);
            kind    = $urandom_range(0, 3);
            r_ld    = (kind == 1);
            r_st    = (kind == 2);
            r_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            cyc(($urandom_range(0, 63) == 0), r_valid, 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), r_rd, r_ld, r_st,
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
